// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file: architectural integer register file for the pipelined ARM CPU.
//   32 x WIDTH registers, two combinational read ports, one synchronous write
//   port. Register ZERO_REG (XZR) has no storage and always reads as zero.
//   A write that is in flight on the WB side is forwarded straight to a
//   matching ID-side read in the same cycle (write-through bypass).
//
// Ports
//   clk            in   1      single clock; all state updates on posedge
//   reset          in   1      synchronous, active-high; clears all registers
//   RegWrite       in   1      write enable from WB stage
//   WriteRegister  in   5      destination register index
//   WriteData      in   WIDTH  data written to WriteRegister
//   ReadRegister1  in   5      port-1 source index
//   ReadRegister2  in   5      port-2 source index
//   ReadData1      out  WIDTH  port-1 data, combinational
//   ReadData2      out  WIDTH  port-2 data, combinational
// -----------------------------------------------------------------------------

// One bit-slice of a read port: selects one of 32 register bits.
module mux32_1 (
  input  logic [31:0] d_i,
  input  logic [4:0]  sel_i,
  output logic        y_o
);

  // Plain 32:1 selection.
  always_comb begin
    y_o = d_i[sel_i];
  end

endmodule

module reg_file #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [31:0]             we_s;        // one-hot write enables
  logic [31:0][WIDTH-1:0]  reg_val_s;   // current contents of every register
  logic [WIDTH-1:0][31:0]  col_s;       // bit-major view feeding the mux slices
  logic [WIDTH-1:0]        mux1_s;
  logic [WIDTH-1:0]        mux2_s;
  logic                    byp1_s;
  logic                    byp2_s;

  // 5->32 write decoder gated by RegWrite; XZR never gets an enable.
  always_comb begin
    we_s = 32'd0;
    if (RegWrite && (WriteRegister != ZERO_IDX)) begin
      we_s[WriteRegister] = 1'b1;
    end else begin
      we_s = 32'd0;
    end
  end

  // Register storage; the XZR slot is a constant with no flops behind it.
  for (genvar r = 0; r < 32; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign reg_val_s[r] = {WIDTH{1'b0}};
    end else begin : g_store
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;

      // Next-state: load on this register's enable, otherwise hold.
      always_comb begin
        if (we_s[r]) begin
          data_d = WriteData;
        end else begin
          data_d = data_q;
        end
      end

      // State update; reset has priority so a same-cycle write is discarded.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_q <= {WIDTH{1'b0}};
        end else begin
          data_q <= data_d;
        end
      end

      assign reg_val_s[r] = data_q;
    end
  end

  // Transpose register-major storage into one 32-bit column per data bit.
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      for (int r = 0; r < 32; r++) begin
        col_s[b][r] = reg_val_s[r][b];
      end
    end
  end

  // Each read port is WIDTH independent mux32_1 slices.
  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    mux32_1 u_mux1 (
      .d_i   (col_s[b]),
      .sel_i (ReadRegister1),
      .y_o   (mux1_s[b])
    );
    mux32_1 u_mux2 (
      .d_i   (col_s[b]),
      .sel_i (ReadRegister2),
      .y_o   (mux2_s[b])
    );
  end

  // Bypass qualifiers: a live, non-reset write hitting a non-XZR read index.
  always_comb begin
    byp1_s = RegWrite && !reset && (WriteRegister == ReadRegister1) &&
             (ReadRegister1 != ZERO_IDX);
    byp2_s = RegWrite && !reset && (WriteRegister == ReadRegister2) &&
             (ReadRegister2 != ZERO_IDX);
  end

  // Read data: forwarded write data on a bypass hit, stored contents otherwise.
  always_comb begin
    if (byp1_s) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = mux1_s;
    end
    if (byp2_s) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = mux2_s;
    end
  end

endmodule
